// File: rtl/acq_trigger_ctrl_pkg.sv
// Shared types for the acquisition sequencer: FSM state encoding and trigger-mode codes.
// Pure declarations, no logic.
package acq_trigger_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } acq_state_t;

  localparam logic [1:0] TRIG_MODE_AUTO   = 2'b00;
  localparam logic [1:0] TRIG_MODE_NORMAL = 2'b01;
  localparam logic [1:0] TRIG_MODE_SINGLE = 2'b10;

  function automatic logic is_capture(input acq_state_t s);
    return (s == S_PRE) || (s == S_WAIT) || (s == S_POST);
  endfunction

endpackage

// File: rtl/acq_trigger_ctrl_trig_detect.sv
// Level/edge trigger detector: keeps the previous captured sample and flags a threshold crossing.
// Latency: hit is combinational on the strobe cycle; prev updates one clock later.
// Backpressure: none, driven purely by sample_en.
module acq_trigger_ctrl_trig_detect #(
  parameter int DATA_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic              track,
  input  logic              eval,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  output logic              hit
);

  logic [DATA_W-1:0] prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else if (sample_en && track) begin
      prev <= data;
    end
  end

  always_comb begin
    hit = 1'b0;
    if (sample_en && eval) begin
      if (trig_edge) hit = (prev >= trig_level) && (data < trig_level);
      else           hit = (prev <  trig_level) && (data >= trig_level);
    end
  end

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Acquisition sequencer: paces capture-RAM writes, holds a pre-trigger window, completes the frame, re-arms.
// Latency: one clock from sample strobe to RAM write; frame_ready pulses on DONE entry.
// Backpressure: none, the capture RAM accepts every write and sample_en paces all progress.
module acq_trigger_ctrl
  import acq_trigger_ctrl_pkg::*;
#(
  parameter int DATA_W       = 12,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 640,
  parameter int PRETRIG      = 64,
  parameter int AUTO_SAMPLES = 4096,
  parameter int HOLDOFF      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [1:0]        trig_mode,
  input  logic              rearm,
  input  logic              hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] frame_start,
  output logic              frame_ready,
  output logic              auto_trig,
  output logic              capturing,
  output logic [2:0]        state
);

  localparam int CNT_W = $clog2(DEPTH + HOLDOFF + 1);
  localparam int TO_W  = $clog2(AUTO_SAMPLES + 1);

  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] WRAP_OFS  = ADDR_W'(DEPTH - PRETRIG);
  localparam logic [CNT_W-1:0]  PRE_END   = CNT_W'(PRETRIG - 1);
  localparam logic [CNT_W-1:0]  POST_END  = CNT_W'(DEPTH - PRETRIG - 1);
  localparam logic [CNT_W-1:0]  HOLD_END  = CNT_W'(HOLDOFF - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_SAMPLES - 1);

  acq_state_t        st;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   tcnt;
  logic              rearm_pend;
  logic              hit;
  logic              force_trig;
  logic              mode_single;
  logic [ADDR_W-1:0] fstart;

  acq_trigger_ctrl_trig_detect #(.DATA_W(DATA_W)) u_trig (
    .clock      (clock),
    .reset_n    (reset_n),
    .sample_en  (sample_en),
    .track      (is_capture(st)),
    .eval       (st == S_WAIT),
    .data       (data),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .hit        (hit)
  );

  assign mode_single = (trig_mode == TRIG_MODE_SINGLE);
  // tcnt saturates, so switching into auto after a long normal wait fires on the next strobe
  assign force_trig  = (trig_mode == TRIG_MODE_AUTO) && (tcnt == TO_LAST);
  assign fstart      = (ptr >= PRE_OFS) ? (ptr - PRE_OFS) : (ptr + WRAP_OFS);
  assign capturing   = is_capture(st);
  assign state       = st;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      rearm_pend  <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_start <= '0;
      frame_ready <= 1'b0;
      auto_trig   <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_ready <= 1'b0;

      if (sample_en && is_capture(st)) begin
        wr_en   <= 1'b1;
        wr_addr <= ptr;
        wr_data <= data;
        ptr     <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end

      case (st)
        S_IDLE: if (!hold) begin
          st  <= S_PRE;
          cnt <= '0;
        end
        S_PRE: if (sample_en) begin
          if (cnt == PRE_END) begin
            st   <= S_WAIT;
            cnt  <= '0;
            tcnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: if (sample_en) begin
          if (hit || force_trig) begin
            // the trigger sample is the first of the post-trigger run
            st          <= S_POST;
            cnt         <= CNT_W'(1);
            frame_start <= fstart;
            auto_trig   <= !hit;
          end else if (tcnt != TO_LAST) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_POST: if (sample_en) begin
          if (cnt == POST_END) begin
            st          <= S_DONE;
            cnt         <= '0;
            frame_ready <= 1'b1;
            rearm_pend  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (rearm && !hold) rearm_pend <= 1'b1;
          if (sample_en && !hold) begin
            if (mode_single) begin
              if (rearm || rearm_pend) begin
                st         <= S_PRE;
                cnt        <= '0;
                rearm_pend <= 1'b0;
              end
            end else if (cnt == HOLD_END) begin
              st         <= S_PRE;
              cnt        <= '0;
              rearm_pend <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// Scoreboard bench for acq_trigger_ctrl: directed scenarios then randomized strobes vs a behavioural model.
module tb_acq_trigger_ctrl;

  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int PRETRIG = 4;
  localparam int AUTO_N  = 8;
  localparam int HOLDOFF = 2;

  logic              clock;
  logic              reset_n;
  logic              sample_en;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] trig_level;
  logic              trig_edge;
  logic [1:0]        trig_mode;
  logic              rearm;
  logic              hold;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] frame_start;
  logic              frame_ready;
  logic              auto_trig;
  logic              capturing;
  logic [2:0]        state;

  acq_trigger_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PRETRIG(PRETRIG),
    .AUTO_SAMPLES(AUTO_N), .HOLDOFF(HOLDOFF)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sample_en(sample_en), .data(data),
    .trig_level(trig_level), .trig_edge(trig_edge), .trig_mode(trig_mode),
    .rearm(rearm), .hold(hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .frame_ready(frame_ready), .auto_trig(auto_trig),
    .capturing(capturing), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int addr; int dat; } wr_t;
  typedef struct { int fs; int at; } frm_t;

  wr_t  wq[$];
  frm_t fq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   frames_seen = 0;

  // reference model: phase numbers are the externally visible state codes
  int m_phase, m_ptr, m_prev, m_cnt, m_wait, m_fs, m_auto;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_prev = 0; m_cnt = 0; m_wait = 0; m_fs = 0; m_auto = 0;
    wq.delete();
    fq.delete();
  endtask

  task automatic model_step(input int d);
    bit cap, h;
    int lvl;
    lvl = int'(trig_level);
    cap = (m_phase >= 1 && m_phase <= 3);
    if (cap) wq.push_back('{addr: m_ptr, dat: d});
    case (m_phase)
      1: begin
        m_cnt++;
        if (m_cnt == PRETRIG) begin m_phase = 2; m_wait = 0; end
      end
      2: begin
        h = trig_edge ? (m_prev >= lvl && d < lvl) : (m_prev < lvl && d >= lvl);
        m_wait++;
        if (h || (trig_mode == 2'b00 && m_wait >= AUTO_N)) begin
          m_fs = (m_ptr - PRETRIG + DEPTH) % DEPTH;
          m_auto = h ? 0 : 1;
          m_cnt = 1;
          m_phase = 3;
        end
      end
      3: begin
        m_cnt++;
        if (m_cnt == DEPTH - PRETRIG) begin
          fq.push_back('{fs: m_fs, at: m_auto});
          m_phase = 4;
          m_cnt = 0;
        end
      end
      4: if (!hold) begin
        if (trig_mode == 2'b10) begin
          if (rearm) begin m_phase = 1; m_cnt = 0; end
        end else begin
          m_cnt++;
          if (m_cnt == HOLDOFF) begin m_phase = 1; m_cnt = 0; end
        end
      end
      default: ;
    endcase
    if (cap) begin
      m_prev = d;
      m_ptr = (m_ptr + 1) % DEPTH;
    end
  endtask

  // one strobe every 4 clocks; inputs change at negedge
  task automatic strobe(input int d);
    sample_en = 1'b1;
    data = DATA_W'(d);
    model_step(d);
    @(negedge clock);
    sample_en = 1'b0;
    rearm = 1'b0;
    chk("state", int'(state), m_phase);
    chk("capturing", int'(capturing), (m_phase >= 1 && m_phase <= 3) ? 1 : 0);
    repeat (3) @(negedge clock);
  endtask

  task automatic run_until(input int ph, input int d, input int maxn);
    int n;
    n = 0;
    while (m_phase != ph && n < maxn) begin
      strobe(d);
      n++;
    end
    if (m_phase != ph) chk("phase_bound", m_phase, ph);
  endtask

  always @(posedge clock) begin
    wr_t  w;
    frm_t f;
    #1;
    if (reset_n) begin
      if (wr_en) begin
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", int'(wr_addr), w.addr);
          chk("wr_data", int'(wr_data), w.dat);
        end
      end
      if (frame_ready) begin
        frames_seen++;
        if (fq.size() == 0) chk("frame_unexpected", 1, 0);
        else begin
          f = fq.pop_front();
          chk("frame_start", int'(frame_start), f.fs);
          chk("auto_trig", int'(auto_trig), f.at);
        end
      end
    end
  end

  initial begin
    int fb;
    reset_n = 1'b1; sample_en = 1'b0; data = '0; trig_level = 12'd100;
    trig_edge = 1'b0; trig_mode = 2'b01; rearm = 1'b0; hold = 1'b0;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_frame_ready", int'(frame_ready), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_auto_trig", int'(auto_trig), 0);
    chk("rst_capturing", int'(capturing), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    m_phase = 1;
    chk("idle_to_pre", int'(state), 1);
    repeat (2) @(negedge clock);

    // normal rising, crossing at address 6
    repeat (4) strobe(90);
    strobe(90); strobe(90);
    fb = frames_seen;
    strobe(110);
    chk("t2_trig_state", int'(state), 3);
    run_until(4, 77, 20);
    chk("t2_frame_start", int'(frame_start), 2);
    chk("t2_one_frame", frames_seen, fb + 1);

    // normal falling, stuck high then drop
    trig_edge = 1'b1;
    run_until(1, 200, 10);
    repeat (4) strobe(200);
    fb = frames_seen;
    repeat (100) strobe(200);
    chk("t3_still_wait", int'(state), 2);
    chk("t3_no_frame", frames_seen, fb);
    strobe(50);
    run_until(4, 50, 20);
    chk("t3_auto_trig", int'(auto_trig), 0);

    // auto timeout with flat data
    trig_mode = 2'b00; trig_edge = 1'b0;
    run_until(2, 0, 20);
    repeat (7) strobe(0);
    chk("t4_pre_timeout", int'(state), 2);
    strobe(0);
    chk("t4_forced", int'(state), 3);
    run_until(4, 0, 20);
    chk("t4_auto_trig", int'(auto_trig), 1);
    strobe(0); strobe(0);
    chk("t4_rearmed", int'(state), 1);

    // single mode, rearm, hold
    trig_mode = 2'b10;
    run_until(2, 0, 20);
    strobe(200);
    run_until(4, $urandom_range(0, 255), 20);
    repeat (50) strobe(0);
    chk("t5_single_stays", int'(state), 4);
    rearm = 1'b1;
    strobe(0);
    chk("t5_rearm", int'(state), 1);
    run_until(2, 0, 20);
    strobe(200);
    strobe(5); strobe(6);
    hold = 1'b1;
    run_until(4, 7, 20);
    trig_mode = 2'b01;
    repeat (10) strobe(0);
    chk("t5_hold_frozen", int'(state), 4);
    trig_mode = 2'b10;
    rearm = 1'b1;
    strobe(0);
    chk("t5_hold_beats_rearm", int'(state), 4);
    hold = 1'b0;
    repeat (3) strobe(0);
    chk("t5_no_latent_rearm", int'(state), 4);
    rearm = 1'b1;
    strobe(0);
    chk("t5_rearm2", int'(state), 1);

    // wrap: trigger lands on address 1
    trig_mode = 2'b01; trig_edge = 1'b0;
    run_until(2, 0, 20);
    begin
      int n;
      n = 0;
      do begin strobe(0); n++; end while (m_ptr != 1 && n < 40);
    end
    strobe(200);
    run_until(4, 150, 20);
    chk("t6_frame_start", int'(frame_start), 13);

    // async reset in the middle of POST
    run_until(2, 0, 20);
    strobe(200);
    repeat (3) strobe(33);
    chk("t1_in_post", int'(state), 3);
    reset_n = 1'b0;
    #1;
    chk("t1_state", int'(state), 0);
    chk("t1_wr_en", int'(wr_en), 0);
    chk("t1_frame_ready", int'(frame_ready), 0);
    chk("t1_frame_start", int'(frame_start), 0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    m_phase = 1;
    chk("t1_to_pre", int'(state), 1);
    repeat (2) @(negedge clock);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) trig_level = DATA_W'($urandom_range(40, 200));
      if ($urandom_range(0, 15) == 0) trig_edge = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) trig_mode = 2'($urandom_range(0, 3));
      rearm = ($urandom_range(0, 5) == 0);
      strobe($urandom_range(0, 255));
    end

    repeat (4) @(negedge clock);
    chk("writes_drained", wq.size(), 0);
    chk("frames_drained", fq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
